// File: rtl/io_periph_pkg.sv
// io_periph_pkg: shared register map, bit positions and helpers for the io_periph block
package io_periph_pkg;
  localparam logic [9:0] IO_BASE   = 10'h100;
  localparam logic [7:0] IO_BTN    = 8'h00;
  localparam logic [7:0] IO_PRESS  = 8'h02;
  localparam logic [7:0] IO_LED    = 8'h04;
  localparam logic [7:0] IO_TIMER  = 8'h06;
  localparam logic [7:0] IO_FRAMES = 8'h08;
  localparam logic [7:0] IO_STATUS = 8'h0A;
  localparam logic [7:0] IO_IRQEN  = 8'h0C;
  localparam int ST_VSYNC  = 0;
  localparam int ST_PRESS  = 1;
  localparam int IRQ_VSYNC = ST_VSYNC;
  localparam int IRQ_PRESS = ST_PRESS;
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction
endpackage

// File: rtl/io_periph_sync2.sv
// sync2: two-flop synchroniser; d_i asynchronous input, q_o synchronised to clk
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) {q_o, meta_q} <= '0;
    else {q_o, meta_q} <= {meta_q, d_i};
endmodule

// File: rtl/io_periph.sv
// io_periph: CPU-bus I/O responder (buttons, press flags, LEDs, timer, frame counter, irq)
//   clk/nreset: CPU clock, async active-low reset
//   sel/en/wr/wide/addr/din/dout: bus access (registered read data, 1-cycle latency)
//   btn_raw/vsync_raw: asynchronous inputs; led: LED register; irq: registered level irq
module io_periph
  import io_periph_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMER_PRESCALE  = 25
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        sel,
  input  logic        en,
  input  logic        wr,
  input  logic        wide,
  input  logic [7:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic [6:0]  btn_raw,
  input  logic        vsync_raw,
  output logic [7:0]  led,
  output logic        irq
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TIMER_PRESCALE + 1);
  logic [6:0] btn_s;
  logic vs_s;
  sync2 #(.WIDTH(7)) u_btn_sync (.clk, .nreset, .d_i(btn_raw), .q_o(btn_s));
  sync2 #(.WIDTH(1)) u_vs_sync (.clk, .nreset, .d_i(vsync_raw), .q_o(vs_s));
  logic [DW-1:0] deb_q, deb_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [6:0] btn_q, btn_d, samp_q, samp_d, press_q, press_d;
  logic [7:0] led_q, led_d;
  logic [15:0] timer_q, timer_d, frames_q, frames_d, dout_q, dout_d;
  logic [1:0] irqen_q, irqen_d;
  logic vs_prev_q, vs_seen_q, vs_seen_d, irq_q, irq_d;
  logic acc_wr, tick, pre_wrap, vs_edge;
  logic [7:0] woff;
  logic [1:0] be, status;
  logic [15:0] wdata, rdata;
  logic [6:0] agree, press_clr;
  always_comb begin
    acc_wr = sel & en & wr;
    woff = {addr[7:1], 1'b0};
    // byte data arrives on din[7:0]; replicate so either lane can take it
    be = wide ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
    wdata = wide ? din : {din[7:0], din[7:0]};
    status = '0;
    status[ST_VSYNC] = vs_seen_q;
    status[ST_PRESS] = |press_q;
    tick = deb_q == DW'(DEBOUNCE_CYCLES - 1);
    deb_d = tick ? '0 : deb_q + DW'(1);
    samp_d = tick ? btn_s : samp_q;
    // a bit moves only when this tick's sample matches the previous tick's
    agree = ~(btn_s ^ samp_q);
    btn_d = tick ? (agree & btn_s) | (~agree & btn_q) : btn_q;
    press_clr = (acc_wr && woff == IO_PRESS && be[0]) ? wdata[6:0] : '0;
    press_d = (press_q & ~press_clr) | (btn_d & ~btn_q);
    led_d = (acc_wr && woff == IO_LED && be[0]) ? wdata[7:0] : led_q;
    pre_wrap = pre_q == PW'(TIMER_PRESCALE - 1);
    timer_d = (acc_wr && woff == IO_TIMER) ? merge(timer_q, wdata, be) : timer_q + 16'(pre_wrap);
    pre_d = ((acc_wr && woff == IO_TIMER) || pre_wrap) ? '0 : pre_q + PW'(1);
    vs_edge = vs_s & ~vs_prev_q;
    frames_d = frames_q + 16'(vs_edge);
    vs_seen_d = (vs_seen_q & ~(acc_wr && woff == IO_STATUS && be[0] && wdata[ST_VSYNC])) | vs_edge;
    irqen_d = (acc_wr && woff == IO_IRQEN && be[0]) ? wdata[1:0] : irqen_q;
    irq_d = |(irqen_q & status);
    rdata = woff == IO_BTN    ? {9'b0, btn_q} :
            woff == IO_PRESS  ? {9'b0, press_q} :
            woff == IO_LED    ? {8'b0, led_q} :
            woff == IO_TIMER  ? timer_q :
            woff == IO_FRAMES ? frames_q :
            woff == IO_STATUS ? {14'b0, status} :
            woff == IO_IRQEN  ? {14'b0, irqen_q} : 16'h0;
    dout_d = (sel & en & ~wr) ? (wide ? rdata : {8'h0, addr[0] ? rdata[15:8] : rdata[7:0]}) : dout_q;
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      deb_q <= '0;
      pre_q <= '0;
      btn_q <= '0;
      samp_q <= '0;
      press_q <= '0;
      led_q <= '0;
      timer_q <= '0;
      frames_q <= '0;
      dout_q <= '0;
      irqen_q <= '0;
      vs_prev_q <= 1'b0;
      vs_seen_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      deb_q <= deb_d;
      pre_q <= pre_d;
      btn_q <= btn_d;
      samp_q <= samp_d;
      press_q <= press_d;
      led_q <= led_d;
      timer_q <= timer_d;
      frames_q <= frames_d;
      dout_q <= dout_d;
      irqen_q <= irqen_d;
      vs_prev_q <= vs_s;
      vs_seen_q <= vs_seen_d;
      irq_q <= irq_d;
    end
  assign dout = dout_q;
  assign led = led_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_io_periph.sv
// tb_io_periph: self-checking bench for io_periph with a read-data scoreboard
module tb_io_periph;
  logic clk = 1'b0, nreset = 1'b0, sel = 1'b0, en = 1'b0, wr = 1'b0, wide = 1'b0;
  logic [7:0] addr = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic [6:0] btn_raw = '0;
  logic vsync_raw = 1'b0;
  logic [7:0] led;
  logic irq;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rd_got, e;

  io_periph #(.DEBOUNCE_CYCLES(4), .TIMER_PRESCALE(2)) dut (
    .clk(clk), .nreset(nreset), .sel(sel), .en(en), .wr(wr), .wide(wide), .addr(addr),
    .din(din), .dout(dout), .btn_raw(btn_raw), .vsync_raw(vsync_raw), .led(led), .irq(irq));

  always #5 clk = ~clk;

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d, input logic w);
    sel = 1'b1; en = 1'b1; wr = 1'b1; wide = w; addr = a; din = d;
    @(negedge clk);
    sel = 1'b0; en = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic w, input logic [15:0] x);
    exp_q.push_back(x);
    sel = 1'b1; en = 1'b1; wr = 1'b0; wide = w; addr = a;
    @(negedge clk);
    sel = 1'b0; en = 1'b0;
    rd_got = dout;
  endtask

  task automatic test_reset();
    logic [7:0] offs [7] = '{8'h00, 8'h02, 8'h04, 8'h08, 8'h0A, 8'h0C, 8'h40};
    repeat (3) @(negedge clk);
    n_cmp++; if ({dout, led, irq} !== 25'h0) begin n_bad++; $display("FAIL in_reset dout/led/irq got %h/%h/%b want 0", dout, led, irq); end
    nreset = 1'b1;
    bus_read(8'h06, 1'b1, 16'h0000);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL reset_timer got %h want %h", rd_got, e); end
    for (int i = 0; i < 7; i++) begin
      bus_read(offs[i], 1'b1, 16'h0000);
      e = exp_q.pop_front(); n_cmp++;
      if (rd_got !== e) begin n_bad++; $display("FAIL reset_read[%h] got %h want %h", offs[i], rd_got, e); end
    end
    n_cmp++; if ({led, irq} !== 9'h0) begin n_bad++; $display("FAIL reset_led_irq got %h/%b want 0", led, irq); end
  endtask

  task automatic test_led();
    bus_write(8'h04, 16'h1234, 1'b1);
    bus_read(8'h04, 1'b1, 16'h0034);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL led_word_read got %h want %h", rd_got, e); end
    n_cmp++; if (led !== 8'h34) begin n_bad++; $display("FAIL led_port got %h want 34", led); end
    bus_write(8'h05, 16'h005A, 1'b0);
    n_cmp++; if (led !== 8'h34) begin n_bad++; $display("FAIL led_odd_byte got %h want 34", led); end
    bus_read(8'h05, 1'b0, 16'h0000);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL led_hi_byte got %h want %h", rd_got, e); end
    bus_write(8'h04, 16'h0077, 1'b0);
    bus_read(8'h04, 1'b0, 16'h0077);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL led_lo_byte got %h want %h", rd_got, e); end
    en = 1'b1; wr = 1'b1; wide = 1'b1; addr = 8'h04; din = 16'h00FF;
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
    n_cmp++; if (led !== 8'h77) begin n_bad++; $display("FAIL led_nosel got %h want 77", led); end
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 12; i++) begin
      btn_raw = {1'b0, i == 5, 3'b001, 2'b00};
      @(negedge clk);
    end
    btn_raw = 7'h04;
    bus_read(8'h00, 1'b1, 16'h0004);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL btn got %h want %h", rd_got, e); end
    bus_read(8'h02, 1'b1, 16'h0004);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL press got %h want %h", rd_got, e); end
    bus_read(8'h0A, 1'b1, 16'h0002);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL status_mirror got %h want %h", rd_got, e); end
    bus_write(8'h02, 16'h0000, 1'b1);
    bus_read(8'h02, 1'b1, 16'h0004);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL press_w0 got %h want %h", rd_got, e); end
    bus_write(8'h0C, 16'h0002, 1'b1);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_latency got %b want 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set got %b want 1", irq); end
    bus_write(8'h02, 16'h0004, 1'b1);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_hold got %b want 1", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear got %b want 0", irq); end
    bus_read(8'h02, 1'b1, 16'h0000);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL press_w1c got %h want %h", rd_got, e); end
  endtask

  task automatic test_timer();
    bus_write(8'h06, 16'hFFFE, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(8'h06, 1'b1, 16'h0000);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL timer_wrap got %h want %h", rd_got, e); end
    bus_write(8'h06, 16'h1111, 1'b1);
    @(negedge clk);
    bus_write(8'h06, 16'h4000, 1'b1);
    bus_read(8'h06, 1'b1, 16'h4000);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL timer_write_wins got %h want %h", rd_got, e); end
    bus_read(8'h07, 1'b0, 16'h0040);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL timer_hi_byte got %h want %h", rd_got, e); end
  endtask

  task automatic test_vsync();
    for (int i = 0; i < 3; i++) begin
      vsync_raw = 1'b1; repeat (4) @(negedge clk);
      vsync_raw = 1'b0; repeat (4) @(negedge clk);
    end
    bus_read(8'h08, 1'b1, 16'h0003);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL frames got %h want %h", rd_got, e); end
    bus_read(8'h0A, 1'b1, 16'h0001);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL status_vs got %h want %h", rd_got, e); end
    bus_write(8'h0A, 16'h0001, 1'b1);
    bus_read(8'h0A, 1'b1, 16'h0000);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL status_w1c got %h want %h", rd_got, e); end
    vsync_raw = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(8'h0A, 16'h0001, 1'b1);
    bus_read(8'h0A, 1'b1, 16'h0001);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL status_set_wins got %h want %h", rd_got, e); end
    bus_read(8'h08, 1'b1, 16'h0004);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL frames_4 got %h want %h", rd_got, e); end
    vsync_raw = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b1; en = 1'b1; wr = 1'b1; wide = 1'b1; addr = 8'h06; din = 16'hABCD;
    #2 nreset = 1'b0;
    @(negedge clk);
    sel = 1'b0; en = 1'b0; wr = 1'b0;
    @(negedge clk);
    n_cmp++; if ({led, irq} !== 9'h0) begin n_bad++; $display("FAIL mid_reset_led_irq got %h/%b want 0", led, irq); end
    nreset = 1'b1;
    bus_read(8'h06, 1'b1, 16'h0000);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL mid_reset_timer got %h want %h", rd_got, e); end
    bus_read(8'h0C, 1'b1, 16'h0000);
    e = exp_q.pop_front(); n_cmp++;
    if (rd_got !== e) begin n_bad++; $display("FAIL mid_reset_irqen got %h want %h", rd_got, e); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_debounce();
    test_timer();
    test_vsync();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
